// File: rtl/dot_product_engine.sv
// Multi-cycle dot product of two N-element vectors, LANES multiply-accumulates per beat.
// Operands are captured on acceptance; the result is held on c until the output handshake.
`timescale 1ns/1ps
module dot_product_engine #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 8,
  parameter int unsigned LANES = 2,
  localparam int unsigned ACC_W = 2 * WIDTH + $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               signed_mode,
  input  logic [WIDTH*N-1:0] a,
  input  logic [WIDTH*N-1:0] b,
  input  logic               abort,
  output logic [ACC_W-1:0]   c,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);

  localparam int unsigned BEATS  = N / LANES;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned EXT_W  = ACC_W - WIDTH;

  typedef enum logic [1:0] {StIdle, StCalc, StOut} state_e;

  state_e               state_q, state_d;
  logic [WIDTH*N-1:0]   a_q, a_d, b_q, b_d;
  logic                 signed_q, signed_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [ACC_W-1:0]     c_q, c_d;
  logic                 out_valid_q, out_valid_d;

  logic [ACC_W-1:0]     prod [LANES];
  logic [ACC_W-1:0]     beat_sum;
  logic [ACC_W-1:0]     acc_next;

  // The operand registers shift down one beat per cycle, so each lane always
  // reads a fixed low slice instead of a beat-indexed one.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [WIDTH-1:0] a_el, b_el;
    logic [ACC_W-1:0] a_ext, b_ext;

    assign a_el  = a_q[l*WIDTH +: WIDTH];
    assign b_el  = b_q[l*WIDTH +: WIDTH];
    assign a_ext = signed_q ? {{EXT_W{a_el[WIDTH-1]}}, a_el} : {{EXT_W{1'b0}}, a_el};
    assign b_ext = signed_q ? {{EXT_W{b_el[WIDTH-1]}}, b_el} : {{EXT_W{1'b0}}, b_el};
    assign prod[l] = a_ext * b_ext;
  end

  always_comb begin
    beat_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      beat_sum = beat_sum + prod[l];
    end
    acc_next = acc_q + beat_sum;
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    signed_d    = signed_q;
    acc_d       = acc_q;
    beat_d      = beat_q;
    c_d         = c_q;
    out_valid_d = out_valid_q;

    // Abort outranks acceptance, beat advance and handshake; c is left intact.
    if (abort) begin
      if (state_q != StIdle) begin
        state_d     = StIdle;
        out_valid_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_d      = a;
            b_d      = b;
            signed_d = signed_mode;
            acc_d    = '0;
            beat_d   = '0;
            state_d  = StCalc;
          end
        end
        StCalc: begin
          acc_d  = acc_next;
          a_d    = a_q >> (LANES * WIDTH);
          b_d    = b_q >> (LANES * WIDTH);
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            c_d         = acc_next;
            out_valid_d = 1'b1;
            state_d     = StOut;
          end
        end
        StOut: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      signed_q    <= 1'b0;
      acc_q       <= '0;
      beat_q      <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      signed_q    <= signed_d;
      acc_q       <= acc_d;
      beat_q      <= beat_d;
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign c         = c_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_dot_product_engine.sv
// Directed bench for dot_product_engine at WIDTH=8, N=4; extra instances with
// LANES=1 and LANES=4 share the stimulus for the lane-count sweep.
`timescale 1ns/1ps
module tb_dot_product_engine;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned N     = 4;
  localparam int unsigned ACC_W = 18;

  logic             clk, rst, in_valid, signed_mode, abort, out_ready;
  logic [WIDTH*N-1:0] a, b;
  logic             in_ready, out_valid, busy;
  logic [ACC_W-1:0] c;
  logic             in_ready_l1, out_valid_l1, busy_l1;
  logic [ACC_W-1:0] c_l1;
  logic             in_ready_l4, out_valid_l4, busy_l4;
  logic [ACC_W-1:0] c_l4;

  int checks = 0;
  int errors = 0;
  logic [ACC_W-1:0] last_c;

  dot_product_engine #(.WIDTH(WIDTH), .N(N), .LANES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .signed_mode(signed_mode), .a(a), .b(b), .abort(abort), .c(c),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  dot_product_engine #(.WIDTH(WIDTH), .N(N), .LANES(1)) dut_l1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l1),
    .signed_mode(signed_mode), .a(a), .b(b), .abort(abort), .c(c_l1),
    .out_valid(out_valid_l1), .out_ready(out_ready), .busy(busy_l1)
  );

  dot_product_engine #(.WIDTH(WIDTH), .N(N), .LANES(4)) dut_l4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l4),
    .signed_mode(signed_mode), .a(a), .b(b), .abort(abort), .c(c_l4),
    .out_valid(out_valid_l4), .out_ready(out_ready), .busy(busy_l4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input logic [7:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one job for a single edge, then scrambles the operand inputs.
  task automatic start_job(input logic [31:0] av, bv, input logic m);
    a = av;
    b = bv;
    signed_mode = m;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    signed_mode = ~m;
  endtask

  task automatic run_job(input logic [31:0] av, bv, input logic m,
                         output logic [ACC_W-1:0] res, output int lat);
    res = '0;
    lat = -1;
    start_job(av, bv, m);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (out_valid) begin
        lat = k;
        res = c;
        break;
      end
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if ({c, out_valid, busy, in_ready} !== {18'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset: c=%0d ov=%b busy=%b ir=%b, required c=0 ov=0 busy=0 ir=1",
               c, out_valid, busy, in_ready);
    end
    last_c = '0;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    start_job(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1'b0);
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b010) begin
      errors++;
      $display("FAIL basic_accept: ir/busy/ov=%b required 010", {in_ready, busy, out_valid});
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early: out_valid=%b required 0 one cycle after accept", out_valid);
    end
    step();
    checks++;
    if ({out_valid, c} !== {1'b1, 18'd70}) begin
      errors++;
      $display("FAIL basic_result: ov=%b c=%0d required ov=1 c=70", out_valid, c);
    end
    step();
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL basic_idle: ov/ir/busy=%b required 010", {out_valid, in_ready, busy});
    end
    last_c = 18'd70;
  endtask

  task automatic test_signed_unsigned();
    logic [ACC_W-1:0] res;
    int lat;
    out_ready = 1'b1;
    run_job(32'hFFFF_FFFF, 32'h0202_0202, 1'b1, res, lat);
    checks++;
    if (res !== 18'h3FFF8 || lat != 2) begin
      errors++;
      $display("FAIL signed_neg: c=%h lat=%0d required c=3fff8 lat=2", res, lat);
    end
    run_job(32'hFFFF_FFFF, 32'h0202_0202, 1'b0, res, lat);
    checks++;
    if (res !== 18'd2040 || lat != 2) begin
      errors++;
      $display("FAIL unsigned_ff02: c=%0d lat=%0d required c=2040 lat=2", res, lat);
    end
    run_job(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, res, lat);
    checks++;
    if (res !== 18'd260100) begin
      errors++;
      $display("FAIL unsigned_max: c=%0d required 260100", res);
    end
    run_job(32'h8080_8080, 32'h8080_8080, 1'b1, res, lat);
    checks++;
    if (res !== 18'd65536) begin
      errors++;
      $display("FAIL signed_min: c=%0d required 65536", res);
    end
    last_c = 18'd65536;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    start_job(pk(2, 2, 2, 2), pk(3, 3, 3, 3), 1'b0);
    step();
    step();
    checks++;
    if ({out_valid, c} !== {1'b1, 18'd24}) begin
      errors++;
      $display("FAIL bp_result: ov=%b c=%0d required ov=1 c=24", out_valid, c);
    end
    for (int i = 0; i < 5; i++) begin
      a = pk(9, 9, 9, 9);
      b = pk(9, 9, 9, 9);
      in_valid = 1'b1;
      step();
      checks++;
      if ({out_valid, in_ready, busy, c} !== {3'b101, 18'd24}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: ov/ir/busy=%b c=%0d required 101 c=24",
                 i, {out_valid, in_ready, busy}, c);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL bp_release: ov/ir/busy=%b required 010", {out_valid, in_ready, busy});
    end
    step();
    checks++;
    if ({busy, c} !== {1'b0, 18'd24}) begin
      errors++;
      $display("FAIL bp_no_queue: busy=%b c=%0d required busy=0 c=24", busy, c);
    end
    last_c = 18'd24;
  endtask

  task automatic test_abort();
    logic [ACC_W-1:0] res;
    int lat;
    logic seen;
    out_ready = 1'b1;
    start_job(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({out_valid, busy, in_ready, c} !== {3'b001, last_c}) begin
      errors++;
      $display("FAIL abort_calc: ov/busy/ir=%b c=%0d required 001 c=%0d",
               {out_valid, busy, in_ready}, c, last_c);
    end
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      seen = seen | out_valid;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_pulse: out_valid seen=%b required 0", seen);
    end
    a = pk(1, 1, 1, 1);
    b = pk(1, 1, 1, 1);
    in_valid = 1'b1;
    abort = 1'b1;
    step();
    in_valid = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle_block: busy=%b required 0", busy);
    end
    run_job(pk(1, 1, 1, 1), pk(1, 1, 1, 1), 1'b0, res, lat);
    checks++;
    if (res !== 18'd4 || lat != 2) begin
      errors++;
      $display("FAIL abort_recover: c=%0d lat=%0d required c=4 lat=2", res, lat);
    end
    out_ready = 1'b0;
    start_job(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1'b0);
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    out_ready = 1'b1;
    checks++;
    if ({out_valid, busy, c} !== {2'b00, 18'd70}) begin
      errors++;
      $display("FAIL abort_out: ov/busy=%b c=%0d required 00 c=70", {out_valid, busy}, c);
    end
    last_c = 18'd70;
  endtask

  task automatic test_rst_mid_calc();
    logic seen;
    out_ready = 1'b1;
    start_job(pk(4, 4, 4, 4), pk(4, 4, 4, 4), 1'b0);
    rst = 1'b1;
    abort = 1'b1;
    step();
    rst = 1'b0;
    abort = 1'b0;
    checks++;
    if ({c, out_valid, busy, in_ready} !== {18'd0, 3'b001}) begin
      errors++;
      $display("FAIL rst_mid: c=%0d ov/busy/ir=%b required c=0 001", c, {out_valid, busy, in_ready});
    end
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      seen = seen | out_valid | (c != 18'd0);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_stale: stale output seen=%b required 0", seen);
    end
  endtask

  task automatic test_lane_sweep();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic        vm [3];
    logic [ACC_W-1:0] ve [3];
    logic [ACC_W-1:0] r1, r2, r4;
    int l1, l2, l4;
    va[0] = pk(1, 2, 3, 4); vb[0] = pk(5, 6, 7, 8); vm[0] = 1'b0; ve[0] = 18'd70;
    va[1] = 32'hFFFF_FFFF;  vb[1] = 32'h0202_0202;  vm[1] = 1'b1; ve[1] = 18'h3FFF8;
    va[2] = 32'h8080_8080;  vb[2] = 32'h8080_8080;  vm[2] = 1'b1; ve[2] = 18'd65536;
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      l1 = -1; l2 = -1; l4 = -1;
      r1 = '0; r2 = '0; r4 = '0;
      start_job(va[v], vb[v], vm[v]);
      for (int k = 1; k <= 8; k++) begin
        step();
        if (out_valid_l1 && l1 < 0) begin l1 = k; r1 = c_l1; end
        if (out_valid    && l2 < 0) begin l2 = k; r2 = c;    end
        if (out_valid_l4 && l4 < 0) begin l4 = k; r4 = c_l4; end
      end
      checks++;
      if (r1 !== ve[v] || l1 != 4) begin
        errors++;
        $display("FAIL sweep_l1[%0d]: c=%h lat=%0d required c=%h lat=4", v, r1, l1, ve[v]);
      end
      checks++;
      if (r2 !== ve[v] || l2 != 2) begin
        errors++;
        $display("FAIL sweep_l2[%0d]: c=%h lat=%0d required c=%h lat=2", v, r2, l2, ve[v]);
      end
      checks++;
      if (r4 !== ve[v] || l4 != 1) begin
        errors++;
        $display("FAIL sweep_l4[%0d]: c=%h lat=%0d required c=%h lat=1", v, r4, l4, ve[v]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    signed_mode = 1'b0;
    abort = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    test_reset();
    test_basic();
    test_signed_unsigned();
    test_backpressure();
    test_abort();
    test_rst_mid_calc();
    test_lane_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
